e203_ifu_flush_rsp: RTL and testbench
=====================================

E203_IFU_FLUSH_RSP -- requirements
Module: e203_ifu_flush_rsp

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, PC and adder width.
REQ-002 SHALL have parameter OUTS_DEPTH, default 2, maximum outstanding fetch requests (1..3).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_1000, fetch PC after reset.
REQ-004 SHALL have one clock and asynchronous, active-high reset; both ports listed first:
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous, active-high reset
REQ-005 SHALL have the flush-receive ports:
  flush_req  in  1  redirect request; held with operands until ack or withdrawn
  flush_add_op1  in  PC_SIZE  target operand 1
  flush_add_op2  in  PC_SIZE  target operand 2
  flush_ack  out  1  redirect accepted this cycle
REQ-006 SHALL have the fetch-request ports:
  ifu_req_valid  out  1  fetch request valid
  ifu_req_ready  in  1  memory accepts request
  ifu_req_pc  out  PC_SIZE  fetch address
REQ-007 SHALL have the response and output ports:
  ifu_rsp_valid  in  1  fetch response valid
  ifu_rsp_instr  in  32  fetched instruction
  ifu_rsp_ready  out  1  constant 1
  ifu_o_valid  out  1  instruction forwarded downstream
  ifu_o_instr  out  32  equals ifu_rsp_instr
  ifu_o_pc  out  PC_SIZE  PC of forwarded instruction
  ifu_halted  out  1  state is HALT

Function
REQ-008 SHALL implement states INIT, FETCH, DRAIN, HALT; INIT always moves to FETCH after one cycle.
REQ-009 SHALL keep outstanding count cnt: +1 on request handshake, -1 on response, unchanged on both; cnt never exceeds OUTS_DEPTH or wraps below 0.
REQ-010 SHALL assert ifu_req_valid only in FETCH with cnt < OUTS_DEPTH and flush_req low; ifu_req_pc = pc_r.
REQ-011 SHALL advance pc_r by 4 (mod 2^PC_SIZE) on each request handshake.
REQ-012 SHALL keep a FIFO of OUTS_DEPTH issued PCs; ifu_o_pc is the head; one entry pops per response.
REQ-013 SHALL assert ifu_o_valid = ifu_rsp_valid only in FETCH with flush_req low; otherwise discard responses (counter and FIFO still updated).
REQ-014 SHALL assert flush_ack combinationally when flush_req is high, cnt == 0 and state is FETCH, DRAIN or HALT; never in INIT.
REQ-015 SHALL, in FETCH with flush_req high and cnt > 0, move to DRAIN.
REQ-016 SHALL stay in DRAIN until cnt == 0, issuing nothing and discarding responses.
REQ-017 SHALL, on the flush_ack cycle, load pc_r with (flush_add_op1 + flush_add_op2) truncated to PC_SIZE, flush the PC FIFO and enter FETCH; first new request is the next cycle.
REQ-018 SHALL, if flush_req drops in DRAIN before ack, finish draining and enter HALT with pc_r unchanged.
REQ-019 SHALL stay in HALT, issuing nothing, until flush_req, then ack per REQ-014/017.
REQ-020 SHALL give flush_req priority over a same-cycle new fetch request.

Reset
REQ-021 SHALL, while rst is high, hold state INIT, cnt 0, pc_r RESET_PC, FIFO empty; flush_ack, ifu_req_valid, ifu_o_valid, ifu_halted = 0; ifu_rsp_ready = 1.
REQ-022 SHALL, on rst mid-DRAIN or mid-flush, discard all in-flight state and restart from INIT; responses after release are counted only if issued after release.

Verification
REQ-023 Reset release, ready=1 every cycle -> INIT one cycle, then requests at 0x1000, 0x1004; third waits for first response.
REQ-024 FETCH, cnt=0, flush_req with op1=0x2000, op2=0x10 -> flush_ack same cycle; next request PC 0x2010.
REQ-025 cnt=2, flush_req held -> DRAIN, no ack, ifu_o_valid=0 for both responses; ack the cycle cnt==0; next PC = op1+op2.
REQ-026 DRAIN, flush_req withdrawn -> HALT after drain, ifu_halted=1, no requests; later flush_req -> immediate ack, fetch resumes at target.
REQ-027 op1=0xFFFF_FFFC, op2=0x8 -> next PC 0x0000_0004 (wrap); request handshake and response same cycle -> cnt unchanged.

Source files
------------

// File: rtl/e203_ifu_flush_rsp.sv
// rtl/e203_ifu_flush_rsp.sv - IFU fetch sequencer with redirect, drain and halt handling
// Issues sequential fetches up to OUTS_DEPTH deep and tracks their PCs until responses return.
module e203_ifu_flush_rsp #(
    parameter int                 PC_SIZE    = 32,
    parameter int                 OUTS_DEPTH = 2,
    parameter logic [PC_SIZE-1:0] RESET_PC   = 32'h0000_1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_req,
    input  logic [PC_SIZE-1:0] flush_add_op1,
    input  logic [PC_SIZE-1:0] flush_add_op2,
    output logic               flush_ack,
    output logic               ifu_req_valid,
    input  logic               ifu_req_ready,
    output logic [PC_SIZE-1:0] ifu_req_pc,
    input  logic               ifu_rsp_valid,
    input  logic [31:0]        ifu_rsp_instr,
    output logic               ifu_rsp_ready,
    output logic               ifu_o_valid,
    output logic [31:0]        ifu_o_instr,
    output logic [PC_SIZE-1:0] ifu_o_pc,
    output logic               ifu_halted
);

    localparam logic [1:0] DEPTH = 2'(OUTS_DEPTH);

    typedef enum logic [1:0] {S_INIT, S_FETCH, S_DRAIN, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [PC_SIZE-1:0] pc_q, pc_d;
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [PC_SIZE-1:0] fifo_q [0:3];
    logic [PC_SIZE-1:0] fifo_d [0:3];

    logic req_hsk;
    logic rsp_pop;

    always_comb begin
        ifu_req_valid = (state_q == S_FETCH) && (cnt_q < DEPTH) && !flush_req;
        req_hsk       = ifu_req_valid && ifu_req_ready;
        // Responses with nothing outstanding are leftovers from before a reset.
        rsp_pop       = ifu_rsp_valid && (cnt_q != 2'd0);
        flush_ack     = flush_req && (cnt_q == 2'd0) && (state_q != S_INIT);
        ifu_o_valid   = rsp_pop && (state_q == S_FETCH) && !flush_req;
        ifu_req_pc    = pc_q;
        ifu_o_pc      = fifo_q[rd_ptr_q];
        ifu_o_instr   = ifu_rsp_instr;
        ifu_rsp_ready = 1'b1;
        ifu_halted    = (state_q == S_HALT);
    end

    always_comb begin
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fifo_d   = fifo_q;
        state_d  = state_q;

        case ({req_hsk, rsp_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        if (flush_ack) begin
            pc_d     = flush_add_op1 + flush_add_op2;
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
        end else begin
            if (req_hsk) begin
                pc_d             = pc_q + PC_SIZE'(4);
                fifo_d[wr_ptr_q] = pc_q;
                wr_ptr_d         = (wr_ptr_q == DEPTH - 2'd1) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (rsp_pop) begin
                rd_ptr_d = (rd_ptr_q == DEPTH - 2'd1) ? 2'd0 : rd_ptr_q + 2'd1;
            end
        end

        case (state_q)
            S_INIT:  state_d = S_FETCH;
            S_FETCH: if (!flush_ack && flush_req) state_d = S_DRAIN;
            S_DRAIN: begin
                if (flush_ack)               state_d = S_FETCH;
                else if (cnt_q == 2'd0)      state_d = S_HALT;
            end
            S_HALT:  if (flush_ack) state_d = S_FETCH;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            cnt_q    <= 2'd0;
            pc_q     <= RESET_PC;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            fifo_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// tb/tb_e203_ifu_flush_rsp.sv - scoreboard bench for e203_ifu_flush_rsp
module tb_e203_ifu_flush_rsp;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic [31:0] flush_add_op1, flush_add_op2;
    logic        flush_ack;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_ready;
    logic        ifu_o_valid;
    logic [31:0] ifu_o_instr, ifu_o_pc;
    logic        ifu_halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_o_pc_q[$];
    logic [31:0] exp_o_instr_q[$];

    e203_ifu_flush_rsp dut (
        .clk(clk), .rst(rst),
        .flush_req(flush_req), .flush_add_op1(flush_add_op1), .flush_add_op2(flush_add_op2),
        .flush_ack(flush_ack),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_o_valid(ifu_o_valid), .ifu_o_instr(ifu_o_instr), .ifu_o_pc(ifu_o_pc),
        .ifu_halted(ifu_halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake and every forwarded instruction must match the next expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifu_req_valid && ifu_req_ready) begin
                if (exp_req_q.size() == 0) check("unexpected_req_pc", ifu_req_pc, 32'hDEAD_BEEF);
                else check("req_pc", ifu_req_pc, exp_req_q.pop_front());
            end
            if (ifu_o_valid) begin
                if (exp_o_pc_q.size() == 0) check("unexpected_o_pc", ifu_o_pc, 32'hDEAD_BEEF);
                else begin
                    check("o_pc", ifu_o_pc, exp_o_pc_q.pop_front());
                    check("o_instr", ifu_o_instr, exp_o_instr_q.pop_front());
                end
            end
        end
    end

    task automatic push_o(input logic [31:0] pc, input logic [31:0] instr);
        exp_o_pc_q.push_back(pc);
        exp_o_instr_q.push_back(instr);
    endtask

    initial begin
        rst = 1'b1; flush_req = 1'b0; flush_add_op1 = '0; flush_add_op2 = '0;
        ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0;
        tick();
        check("rst_flush_ack", {31'd0, flush_ack}, 32'd0);
        check("rst_req_valid", {31'd0, ifu_req_valid}, 32'd0);
        check("rst_o_valid", {31'd0, ifu_o_valid}, 32'd0);
        check("rst_halted", {31'd0, ifu_halted}, 32'd0);
        check("rst_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd1);

        // Reset release: INIT for one cycle, then two requests, third waits.
        exp_req_q.push_back(32'h1000); exp_req_q.push_back(32'h1004);
        rst = 1'b0; flush_req = 1'b1; #1;
        check("init_no_ack", {31'd0, flush_ack}, 32'd0);
        check("init_no_req", {31'd0, ifu_req_valid}, 32'd0);
        flush_req = 1'b0;
        tick(); tick(); tick();
        check("cnt_full_no_req", {31'd0, ifu_req_valid}, 32'd0);
        ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hA0; push_o(32'h1000, 32'hA0);
        exp_req_q.push_back(32'h1008);
        tick();
        ifu_rsp_instr = 32'hB0; push_o(32'h1004, 32'hB0);
        tick();
        ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b0; #1;
        check("same_cycle_cnt_kept", {31'd0, ifu_req_valid}, 32'd1);
        check("pc_after_3", ifu_req_pc, 32'h100C);
        ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hC0; push_o(32'h1008, 32'hC0);
        tick();
        ifu_rsp_valid = 1'b0;

        // Immediate redirect with nothing outstanding.
        flush_req = 1'b1; flush_add_op1 = 32'h2000; flush_add_op2 = 32'h10; #1;
        check("flush_ack_cnt0", {31'd0, flush_ack}, 32'd1);
        check("flush_prio_over_req", {31'd0, ifu_req_valid}, 32'd0);
        exp_req_q.push_back(32'h2010); exp_req_q.push_back(32'h2014);
        ifu_req_ready = 1'b1;
        tick();
        flush_req = 1'b0; #1;
        check("ack_drop", {31'd0, flush_ack}, 32'd0);
        tick(); tick();

        // Redirect with two outstanding: drain, discard, then ack.
        flush_req = 1'b1; flush_add_op1 = 32'h3000; flush_add_op2 = 32'h100; #1;
        check("no_ack_cnt2", {31'd0, flush_ack}, 32'd0);
        tick();
        ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hD0; #1;
        check("drain_o_valid", {31'd0, ifu_o_valid}, 32'd0);
        tick();
        check("no_ack_cnt1", {31'd0, flush_ack}, 32'd0);
        check("drain_o_valid2", {31'd0, ifu_o_valid}, 32'd0);
        tick();
        ifu_rsp_valid = 1'b0; #1;
        check("ack_after_drain", {31'd0, flush_ack}, 32'd1);
        exp_req_q.push_back(32'h3100); exp_req_q.push_back(32'h3104);
        tick();
        flush_req = 1'b0;
        tick(); tick();

        // Withdrawn redirect: drain to HALT, then redirect with wrap-around target.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hE0;
        tick(); tick();
        ifu_rsp_valid = 1'b0;
        tick();
        check("halted", {31'd0, ifu_halted}, 32'd1);
        check("halt_no_req", {31'd0, ifu_req_valid}, 32'd0);
        tick();
        check("still_halted", {31'd0, ifu_halted}, 32'd1);
        flush_req = 1'b1; flush_add_op1 = 32'hFFFF_FFFC; flush_add_op2 = 32'h8; #1;
        check("halt_ack", {31'd0, flush_ack}, 32'd1);
        exp_req_q.push_back(32'h4); exp_req_q.push_back(32'h8);
        tick();
        flush_req = 1'b0; #1;
        check("unhalted", {31'd0, ifu_halted}, 32'd0);
        tick(); tick();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hF0; push_o(32'h4, 32'hF0);
        tick();
        ifu_rsp_instr = 32'hF1; push_o(32'h8, 32'hF1);
        tick();
        ifu_rsp_valid = 1'b0;

        // Reset in the middle of a drain restarts cleanly.
        ifu_req_ready = 1'b1;
        exp_req_q.push_back(32'hC); exp_req_q.push_back(32'h10);
        tick(); tick();
        flush_req = 1'b1;
        tick();
        rst = 1'b1; flush_req = 1'b0; #1;
        check("midrst_req_valid", {31'd0, ifu_req_valid}, 32'd0);
        check("midrst_halted", {31'd0, ifu_halted}, 32'd0);
        tick();
        exp_req_q.push_back(32'h1000); exp_req_q.push_back(32'h1004);
        rst = 1'b0;
        tick(); tick(); tick();
        ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h11; push_o(32'h1000, 32'h11);
        tick();
        ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b0;
        tick(); tick();

        check("req_queue_empty", exp_req_q.size(), 32'd0);
        check("o_queue_empty", exp_o_pc_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
